mem_port_arbiter: RTL and testbench

Arbitrates one shared single-ported memory between the instruction-fetch path and the load/store path of the RISC-V core. Fetch requests come from the PC/fetch stage. Data requests use the `memwrite`/`memsize` decode from the controller. The block registers the winning request onto the memory port, holds it until the memory acknowledges, then routes the acknowledge and read data back to the winner. It also stops issuing new grants once the core signals halt.

---
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 tb/tb_mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch and load/store; request seen in IDLE is on m_* next cycle.
// Holds the grant until m_ack (acks are combinational); defining MEM_ARB_RR_EN makes ties round-robin instead of data-first.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [2:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  input  logic              hlt,
  output logic              halted
);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_D, HALTED} state_t;

  state_t state;
  logic   pick_d;
  logic   grant;

  assign grant = (state == IDLE) && !hlt && (if_req || d_req);

`ifdef MEM_ARB_RR_EN
  logic last_d;

  // On a tie the side that did not win last time goes first; reset means fetch won last.
  assign pick_d = d_req && (!if_req || !last_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b0;
    end else if (grant) begin
      last_d <= pick_d;
    end
  end
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_size  <= 3'b000;
      m_addr  <= '0;
      m_wdata <= '0;
      halted  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hlt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (grant) begin
            m_req <= 1'b1;
            if (pick_d) begin
              state   <= GNT_D;
              m_we    <= d_we;
              m_size  <= d_size;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
            end else begin
              state   <= GNT_IF;
              m_we    <= 1'b0;
              m_size  <= 3'b010;
              m_addr  <= if_addr;
              m_wdata <= '0;
            end
          end
        end
        GNT_IF, GNT_D: begin
          if (m_ack) begin
            m_req  <= 1'b0;
            state  <= hlt ? HALTED : IDLE;
            halted <= hlt;
          end
        end
        HALTED: begin
          m_req <= 1'b0;
        end
        default: begin
          state <= IDLE;
          m_req <= 1'b0;
        end
      endcase
    end
  end

  // Acks follow m_ack in the same cycle, gated by m_req so a stray m_ack is ignored.
  assign if_ack   = (state == GNT_IF) && m_req && m_ack;
  assign d_ack    = (state == GNT_D) && m_req && m_ack;
  assign if_rdata = m_rdata;
  assign d_rdata  = m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 0, d_req = 0, d_we = 0, m_ack = 0, hlt = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
  logic [2:0]  d_size = 0;
  logic        if_ack, d_ack, m_req, m_we, halted;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic [2:0]  m_size;

  int total = 0;
  int bad = 0;

  // Model: one outstanding transaction at most, and who owns it.
  bit          mb_busy, mb_gif, mb_halt, mb_last_d;
  logic        e_we;
  logic [2:0]  e_size;
  logic [31:0] e_addr, e_wdata;
  bit          exp_ia, exp_da, dut_ia, dut_da;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .hlt(hlt), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mb_busy = 0; mb_gif = 0; mb_halt = 0; mb_last_d = 0;
  endtask

  task automatic model_edge();
    bit wd;
    if (mb_halt) begin
    end else if (mb_busy) begin
      if (m_ack) begin
        mb_busy = 0;
        if (hlt) mb_halt = 1;
      end
    end else if (hlt) begin
      mb_halt = 1;
    end else if (if_req || d_req) begin
      if (if_req && d_req) wd = RR ? !mb_last_d : 1'b1;
      else wd = d_req;
      mb_busy = 1; mb_gif = !wd; mb_last_d = wd;
      if (wd) begin
        e_we = d_we; e_size = d_size; e_addr = d_addr; e_wdata = d_wdata;
      end else begin
        e_we = 0; e_size = 3'b010; e_addr = if_addr; e_wdata = 0;
      end
    end
  endtask

  // One clock: check acks mid-cycle, advance model at the edge, check registered outputs after it.
  task automatic cycle();
    @(negedge clk);
    exp_ia = mb_busy && mb_gif && m_ack;
    exp_da = mb_busy && !mb_gif && m_ack;
    dut_ia = if_ack; dut_da = d_ack;
    chk("if_ack", if_ack, exp_ia);
    chk("d_ack", d_ack, exp_da);
    if (exp_ia) chk("if_rdata", if_rdata, m_rdata);
    if (exp_da) chk("d_rdata", d_rdata, m_rdata);
    @(posedge clk);
    model_edge();
    #1;
    chk("m_req", m_req, mb_busy);
    chk("halted", halted, mb_halt);
    if (mb_busy) begin
      chk("m_we", m_we, e_we);
      chk("m_size", m_size, e_size);
      chk("m_addr", m_addr, e_addr);
      chk("m_wdata", m_wdata, e_wdata);
    end
  endtask

  task automatic clear_inputs();
    if_req = 0; d_req = 0; d_we = 0; m_ack = 0; hlt = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; d_size = 0; m_rdata = 0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #2;
    clear_inputs();
    rst_n = 0;
    #1;
    model_reset();
    chk("rst_m_req", m_req, 0);
    @(posedge clk); #2;
    rst_n = 1;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    #2;
    chk("rst_m_req", m_req, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_m_size", m_size, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_halted", halted, 0);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    @(posedge clk); #2;
    rst_n = 1;

    // Contention from reset: both held high, memory acks as soon as m_req is up.
    if_req = 1; if_addr = 32'h10; d_req = 1; d_addr = 32'h20; d_we = 0; d_size = 3'b010;
    for (int i = 0; i < 8; i++) begin
      m_ack = m_req;
      cycle();
      chk("cont_m_req", m_req, (i % 2 == 0));
      if (i % 2 == 0)
        chk("cont_winner", m_addr, (RR && (i % 4 == 2)) ? 32'h10 : 32'h20);
    end

    // Single fetch, acked two cycles after m_req.
    reset_dut();
    if_req = 1; if_addr = 32'h100;
    cycle();
    chk("f_addr", m_addr, 32'h100);
    chk("f_we", m_we, 0);
    chk("f_size", m_size, 3'b010);
    cycle();
    m_ack = 1; m_rdata = 32'hDEADBEEF;
    cycle();
    chk("f_ack", dut_ia, 1);
    if_req = 0; m_ack = 0;
    cycle();
    chk("f_m_req_low", m_req, 0);
    chk("f_no_second_ack", dut_ia, 0);

    // Byte store held until acknowledged.
    d_req = 1; d_we = 1; d_size = 3'b000; d_addr = 32'h2003; d_wdata = 32'hAB;
    cycle();
    chk("s_we", m_we, 1);
    chk("s_size", m_size, 0);
    chk("s_addr", m_addr, 32'h2003);
    chk("s_wdata", m_wdata, 32'hAB);
    cycle();
    cycle();
    chk("s_held_addr", m_addr, 32'h2003);
    m_ack = 1;
    cycle();
    chk("s_ack", dut_da, 1);
    d_req = 0; m_ack = 0;
    cycle();

    // Randomized traffic with a reactive memory and occasional stray m_ack.
    reset_dut();
    for (int n = 0; n < 1500; n++) begin
      if (exp_ia || !if_req) begin
        if_req = ($urandom_range(0, 2) == 0);
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (exp_da || !d_req) begin
        d_req = ($urandom_range(0, 2) == 0);
        d_we = $urandom_range(0, 1);
        d_size = $urandom_range(0, 7);
        d_addr = $urandom;
        d_wdata = $urandom;
      end
      m_rdata = $urandom;
      m_ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      cycle();
    end

    // Halt while a fetch is outstanding and data is waiting.
    reset_dut();
    if_req = 1; if_addr = 32'h300;
    cycle();
    hlt = 1; d_req = 1; d_addr = 32'h400;
    cycle();
    m_ack = 1; m_rdata = 32'h1234_5678;
    cycle();
    chk("h_fetch_done", dut_ia, 1);
    chk("h_halted", halted, 1);
    if_req = 0; m_ack = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("h_m_req_low", m_req, 0);
      chk("h_no_d_ack", dut_da, 0);
    end
    hlt = 0;
    cycle();
    chk("h_stays_halted", halted, 1);

    // Reset between edges while a store is granted.
    reset_dut();
    d_req = 1; d_we = 1; d_addr = 32'h500; d_wdata = 32'h55;
    cycle();
    chk("r_granted", m_req, 1);
    #2;
    rst_n = 0;
    #1;
    chk("r_m_req_drop", m_req, 0);
    model_reset();
    d_req = 0;
    #2;
    rst_n = 1;
    cycle();
    m_ack = 1; m_rdata = 32'h99;
    cycle();
    chk("r_late_ack", dut_da, 0);
    chk("r_m_req_idle", m_req, 0);
    m_ack = 0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
